prbs31_checker: RTL
===================

// Module: prbs31_checker
// PURPOSE
// - Receive-side PRBS31 (x^31 + x^28 + 1) checker. It is the far end of the team's PRBS31 generator,
//   whose serial stream is the generator's lfsr[30] bit.
// - Self-synchronises to the incoming serial stream, declares lock, then counts bit errors.
// - Detects loss of lock and re-acquires without software help.
// - Sits behind an input pin or loopback path. Status and count go to uo_out or a debug mux.
// PARAMETERS
// - LOCK_MATCHES  64  consecutive correct predictions needed in SEARCH to declare lock (range 1..255)
// - LOSS_WIN      64  length, in valid bits, of the loss-of-lock observation window (range 2..255)
// - LOSS_ERRS     8   errors inside one window that force a return to SEARCH (1..LOSS_WIN)
// - ERR_W         16  width of the saturating error counter
// PORTS
// - clk      in   1      single clock, rising edge
// - rst_n    in   1      asynchronous, active-low reset
// - din      in   1      received serial bit
// - din_vld  in   1      din is sampled only when 1; no state changes when 0
// - clr_err  in   1      synchronous clear of err_cnt and err_sat
// - locked   out  1      1 = checker locked to a PRBS31 stream
// - err_pulse out 1      one-cycle pulse per detected bit error (LOCKED only)
// - err_cnt  out  ERR_W  saturating error count since reset or clr_err
// - err_sat  out  1      sticky; err_cnt has reached all-ones
// BEHAVIOUR
// - Reset: state=SEARCH, shreg=0, fill=0, match=0, win=0, win_err=0; all outputs 0.
// - shreg[30:0]: shreg[k] is the bit k+1 valid bits ago. pred = shreg[27] ^ shreg[30].
// - Each valid bit shifts: shreg <= {shreg[29:0], in_bit}.
// - All outputs are registered, 1 cycle after the din_vld beat that causes them.
// - SEARCH state
//   - in_bit = din (self-synchronising).
//   - fill counts valid bits up to 31 and then holds. No compare occurs until fill==31.
//   - When fill==31: if din==pred and shreg!=0, match++; otherwise match=0.
//   - The all-zero register never counts. An all-zero stream never locks.
//   - When match reaches LOCK_MATCHES: next state=LOCKED, locked=1 on the following cycle,
//     win=0, win_err=0.
// - LOCKED state
//   - in_bit = pred (free-running reference). One channel error therefore counts exactly once.
//   - din!=pred: err_pulse=1, err_cnt++ saturating at 2^ERR_W-1 (sets err_sat), win_err++.
//   - win++ per valid bit. When win wraps at LOSS_WIN: win=0, win_err=0.
//   - When win_err reaches LOSS_ERRS (on the error beat): next state=SEARCH, locked=0 next cycle,
//     fill=0, match=0.
//   - shreg is kept when re-entering SEARCH.
//   - The beat that trips loss still pulses err_pulse and counts.
// - Simultaneous events
//   - clr_err with a counted error: err_cnt=1, err_sat=0.
//   - clr_err alone: err_cnt=0, err_sat=0. It does not affect state, lock or window.
//   - Window wrap on the same beat as an error: that error counts in the closing window.
//     The loss check uses the incremented value; then the window resets.
// - Lock loss does not clear err_cnt.
// - rst_n low mid-operation: immediate return to reset values, regardless of clk.
// STRUCTURE
// - Package prbs_pkg holds:
//   - PRBS31_LEN=31 and tap constants TAP_A=27, TAP_B=30, shared with the generator;
//   - function prbs31_next(lfsr) returning the feedback bit;
//   - typedef enum {SEARCH, LOCKED} chk_state_t.
// - No sub-module. A single FSM plus counters is sufficient.
// TESTING
// - Reset: hold rst_n=0 with random din -> locked=0, err_pulse=0, err_cnt=0, err_sat=0.
// - Clean PRBS31 from generator seed 1, din_vld=1 -> locked rises 1 cycle after valid bit 95
//   (31 fill + 64 matches); err_cnt stays 0 for 10000 bits.
// - Locked, flip 1 bit -> exactly one err_pulse, err_cnt=1, locked stays 1.
//   Flip 7 bits within 64 -> err_cnt=8 total, still locked.
// - Locked, 8 flipped bits within one 64-bit window -> locked=0 after the 8th error, err_cnt=8.
//   Clean stream then re-locks after 95 more valid bits.
// - din=0 constant for 1000 bits -> never locked. Random din_vld gaps (~50%) on a clean stream
//   -> same lock point counted in valid bits.
// - ERR_W=4, locked with 20 sparse errors -> err_cnt=15, err_sat=1.
//   clr_err on an error beat -> err_cnt=1, err_sat=0.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) constants, feedback helper and checker state type.
package prbs_pkg;

    localparam int PRBS31_LEN = 31;
    localparam int TAP_A      = 27;
    localparam int TAP_B      = 30;

    // Feedback bit of the PRBS31 register. It is also the next serial bit predicted
    // from the last 31 received bits.
    function automatic logic prbs31_next(input logic [PRBS31_LEN-1:0] lfsr);
        return lfsr[TAP_A] ^ lfsr[TAP_B];
    endfunction

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

endpackage

// File: rtl/prbs31_checker_if.sv
// Serial input, control and status bundle of the PRBS31 checker.
interface prbs31_checker_if #(
    parameter int ERR_W = 16
);
    import prbs_pkg::*;

    logic             din;
    logic             din_vld;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             err_sat;

    modport master (
        output din, din_vld, clr_err,
        input  locked, err_pulse, err_cnt, err_sat
    );

    modport slave (
        input  din, din_vld, clr_err,
        output locked, err_pulse, err_cnt, err_sat
    );

endinterface

// File: rtl/prbs31_checker.sv
// Receive-side PRBS31 checker: self-synchronises in SEARCH, then free-runs its
// reference in LOCKED and counts bit errors, falling back to SEARCH when too many
// errors land inside one observation window.
module prbs31_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_MATCHES = 64,
    parameter int LOSS_WIN     = 64,
    parameter int LOSS_ERRS    = 8,
    parameter int ERR_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    prbs31_checker_if.slave  bus
);

    chk_state_t            state, state_n;
    logic [PRBS31_LEN-1:0] shreg, shreg_n;
    logic [4:0]            fill, fill_n;
    logic [7:0]            match, match_n;
    logic [7:0]            win, win_n;
    logic [7:0]            win_err, win_err_n;
    logic                  pulse, pulse_n;
    logic [ERR_W-1:0]      cnt, cnt_n;
    logic                  sat, sat_n;

    logic                  pred;
    logic [7:0]            match_inc;
    logic [7:0]            win_inc;
    logic [7:0]            win_err_inc;

    assign pred        = prbs31_next(shreg);
    assign match_inc   = match + 8'd1;
    assign win_inc     = win + 8'd1;
    assign win_err_inc = win_err + {7'd0, pulse_n};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_n;
    end

    // Next-state, shift register, lock/window counters and error counter.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        fill_n    = fill;
        match_n   = match;
        win_n     = win;
        win_err_n = win_err;
        pulse_n   = 1'b0;

        if (bus.din_vld) begin
            case (state)
                SEARCH: begin
                    // Load the received bit so the register tracks the line.
                    shreg_n = {shreg[PRBS31_LEN-2:0], bus.din};
                    if (fill != 5'(PRBS31_LEN)) begin
                        fill_n = fill + 5'd1;
                    end else if (bus.din == pred && shreg != '0) begin
                        if (match_inc == 8'(LOCK_MATCHES)) begin
                            state_n   = LOCKED;
                            match_n   = 8'd0;
                            win_n     = 8'd0;
                            win_err_n = 8'd0;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        match_n = 8'd0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a channel error counts only once.
                    shreg_n = {shreg[PRBS31_LEN-2:0], pred};
                    pulse_n = (bus.din != pred);
                    if (win_inc == 8'(LOSS_WIN)) begin
                        win_n     = 8'd0;
                        win_err_n = 8'd0;
                    end else begin
                        win_n     = win_inc;
                        win_err_n = win_err_inc;
                    end
                    // Loss check sees the error just added, even on a window wrap.
                    if (pulse_n && win_err_inc == 8'(LOSS_ERRS)) begin
                        state_n   = SEARCH;
                        fill_n    = 5'd0;
                        match_n   = 8'd0;
                        win_n     = 8'd0;
                        win_err_n = 8'd0;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end

        cnt_n = cnt;
        sat_n = sat;
        if (bus.clr_err) begin
            cnt_n = ERR_W'(pulse_n);
            sat_n = 1'b0;
        end else if (pulse_n && cnt != '1) begin
            cnt_n = cnt + ERR_W'(1);
        end
        if (cnt_n == '1) sat_n = 1'b1;
    end

    // Datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            fill    <= 5'd0;
            match   <= 8'd0;
            win     <= 8'd0;
            win_err <= 8'd0;
            pulse   <= 1'b0;
            cnt     <= '0;
            sat     <= 1'b0;
        end else begin
            shreg   <= shreg_n;
            fill    <= fill_n;
            match   <= match_n;
            win     <= win_n;
            win_err <= win_err_n;
            pulse   <= pulse_n;
            cnt     <= cnt_n;
            sat     <= sat_n;
        end
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.err_pulse = pulse;
    assign bus.err_cnt   = cnt;
    assign bus.err_sat   = sat;

endmodule
